// File: rtl/mux_encoder_rr.sv
// N-channel stream multiplexer with valid/ready on every port and a registered output stage.
// Arbitration is either fixed by `sel` or round-robin with up to BURST beats per grant.
module mux_encoder_rr #(
    parameter int NCH   = 4,
    parameter int W     = 2,
    parameter int SELW  = $clog2(NCH),
    parameter int BURST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH*W-1:0]  in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    // Index space of a SELW-bit channel number; bits at or above NCH are never valid.
    localparam int NSEL = 1 << SELW;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0] cur_q, cur_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;

    logic [NSEL-1:0] valid_ext;
    logic [NSEL-1:0] ready_ext;
    logic            can_load;
    logic            cur_valid;
    logic            xfer;
    logic [W-1:0]    cur_data;
    logic [SELW-1:0] cur_next;
    logic [SELW-1:0] rr_pick;
    logic            rr_found;
    int              scan_idx;

    assign valid_ext = NSEL'(in_valid);
    assign can_load  = !out_valid_q || out_ready;
    assign cur_valid = valid_ext[cur_q];
    assign cur_data  = in_data[int'(cur_q)*W +: W];
    assign xfer      = (state_q == GRANT) && cur_valid && can_load;
    assign cur_next  = (cur_q == SELW'(NCH-1)) ? '0 : cur_q + SELW'(1);

    // First valid channel at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        scan_idx = 0;
        for (int k = 0; k < NCH; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
            if (!rr_found && in_valid[scan_idx]) begin
                rr_found = 1'b1;
                rr_pick  = SELW'(scan_idx);
            end
        end
    end

    always_comb begin
        ready_ext = '0;
        if (state_q == GRANT && can_load) ready_ext[cur_q] = 1'b1;
        in_ready = ready_ext[NCH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        beat_cnt_d  = beat_cnt_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;

        if (xfer) begin
            out_data_d  = cur_data;
            out_ch_d    = cur_q;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!mode) begin
                    if (valid_ext[sel]) begin
                        cur_d      = sel;
                        beat_cnt_d = '0;
                        state_d    = GRANT;
                    end
                end else if (rr_found) begin
                    cur_d      = rr_pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A source that drops valid forfeits the rest of its burst.
                if (!cur_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = cur_next;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == 8'(BURST-1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = cur_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_q       <= cur_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/mux_encoder_rr.md
Name: mux_encoder_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer.
- Next generation of the team's 4:1 select mux for the Tx encoder path.
- Adds valid/ready handshakes on every input channel and on the output, plus a registered output stage.
- Supports two arbitration modes: fixed-select (software `sel`) and round-robin with burst lock.
- Sits between per-source symbol encoders and the shared Tx serialiser.

Parameters:
- NCH, 4: number of input channels (2..16).
- W, 2: data width per channel.
- SELW, $clog2(NCH): width of channel index.
- BURST, 1: maximum beats a channel may send per grant before re-arbitration (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select by `sel`; 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  NCH*W  channel i occupies bits [i*W +: W].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready.
- out_data  output  W  registered output data.
- out_ch  output  SELW  channel index of out_data.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: out_data=0, out_ch=0, out_valid=0, in_ready=0.
  - Internal: state=IDLE, rr_ptr=0, cur=0, beat_cnt=0.
- Output register (single entry):
  - `can_load = !out_valid || out_ready`.
  - Channel `cur` transfers a beat when state=GRANT, in_valid[cur] and can_load.
  - On transfer: out_data <= in_data[cur], out_ch <= cur, out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Latency: input beat accepted in cycle t appears on out_data in cycle t+1.
  - out_data and out_ch hold while out_valid && !out_ready.
- in_ready[i] = (state==GRANT) && (i==cur) && can_load. This is combinational from out_ready. All other bits are 0.
- States:
  - IDLE:
    - mode and sel are sampled only in this state.
    - mode=0: if sel<NCH and in_valid[sel], then cur<=sel, beat_cnt<=0, go GRANT. If sel>=NCH, no grant; stay IDLE.
    - mode=1: cur<=first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NCH. Then beat_cnt<=0, go GRANT. No valid inputs: stay IDLE.
    - The IDLE cycle transfers no data. Arbitration costs 1 cycle per grant.
  - GRANT:
    - On each transfer, beat_cnt increments.
    - Go to IDLE on the transfer where beat_cnt==BURST-1, or on any cycle where in_valid[cur]==0 (no transfer that cycle).
    - On leaving GRANT, rr_ptr <= (cur+1) mod NCH. This wrap-around update happens in both modes.
    - While stalled by !can_load with in_valid[cur]=1, stay in GRANT; beat_cnt is unchanged.
- Boundary rules:
  - BURST=1: each grant moves exactly one beat; steady-state throughput is 1 beat per 2 cycles.
  - mode or sel changes during GRANT take effect at the next IDLE.
  - A channel dropping in_valid mid-burst forfeits the remainder of its burst.
  - Reset during GRANT drops the beat held in the output register and returns to IDLE.
- Width rule: data passes unmodified; out_ch is zero-extended SELW.

Test Plan:
- Reset with all in_valid=1, then release with mode=1, NCH=4, W=2, BURST=1, in_data={2'b11,2'b10,2'b01,2'b00}, out_ready=1 -> out_data 00,01,10,11,00 with out_ch 0,1,2,3,0, one beat every 2 cycles.
- mode=0, sel=2, only in_valid[2]=1 with data 2'b10, out_ready=1 -> in_ready=4'b0100 in GRANT; out_data=2'b10, out_ch=2 one cycle after acceptance. Then sel=3 with in_valid[3]=0 -> no grant, out_valid falls to 0.
- BURST=3, mode=1, in_valid=4'b0011 held -> out_ch sequence 0,0,0,1,1,1,0, with one dead IDLE cycle between bursts.
- Backpressure: out_ready=0 for 5 cycles while in GRANT -> out_valid=1 and out_data/out_ch stable; in_ready=0; beat_cnt unchanged. Release -> next beat on the following cycle, no loss or duplication.
- Channel 1 drops in_valid after 1 of BURST=4 beats -> return to IDLE, rr_ptr=2, next grant to channel 2 if valid.
- Assert rst_n=0 mid-burst with out_valid=1 -> out_valid=0 and in_ready=0 immediately (asynchronously); after release, arbitration restarts from channel 0.
